// File: rtl/dcpu_board_pkg.sv
// Shared definitions for the board-side CPU execution controller:
// FSM state encoding and default timing constants.
package dcpu_board_pkg;

  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2
  } state_t;

  localparam int DEF_DIV_BITS  = 15;
  localparam int DEF_DB_CYCLES = 1_000_000;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stability-counter debounce,
// and a one-cycle pulse on each accepted 0->1 transition.
module btn_debounce
  import dcpu_board_pkg::*;
#(
  parameter int DB_CYCLES = DEF_DB_CYCLES
) (
  input  logic clk_in,
  input  logic reset,
  input  logic btn_raw,
  output logic press
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic [1:0]    sync;
  logic          level;
  logic          accepted;
  logic [CW-1:0] cnt;

  assign level = sync[1];

  // The counter only advances while the synced level disagrees with the
  // accepted one; any return to agreement restarts the stability window.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      sync     <= '0;
      accepted <= 1'b0;
      cnt      <= '0;
      press    <= 1'b0;
    end else begin
      sync  <= {sync[0], btn_raw};
      press <= 1'b0;
      if (level == accepted) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        accepted <= level;
        cnt      <= '0;
        press    <= level;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/dcpu_clk_ctrl.sv
// Execution controller: conditions board inputs and issues a single-cycle
// cpu_tick enable under a RUN / HALT / STEP state machine.
//
// state | meaning
// ------+---------------------------------------------------------------
// HALT  | core paused; no ticks; waits for a run or step press
// RUN   | free-running; one tick per divider wrap
// STEP  | one tick pending; issued on the next divider wrap, then HALT
module dcpu_clk_ctrl
  import dcpu_board_pkg::*;
#(
  parameter int DIV_BITS  = DEF_DIV_BITS,
  parameter int DB_CYCLES = DEF_DB_CYCLES,
  parameter bit START_RUN = 1'b1
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        btn_run,
  input  logic        btn_step,
  input  logic        sw_stop,
  input  logic [1:0]  choice_raw,
  input  logic [4:0]  raddr_raw,
  output logic        cpu_tick,
  output logic        running,
  output logic [1:0]  choice,
  output logic [4:0]  raddr,
  output logic [15:0] tick_cnt
);

  state_t              state;
  logic [1:0]          stop_sync;
  logic                stop;
  logic [1:0]          choice_s1;
  logic [4:0]          raddr_s1;
  logic [DIV_BITS-1:0] div_cnt;
  logic                div_tick;
  logic                run_press;
  logic                step_press;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_run (
    .clk_in  (clk_in),
    .reset   (reset),
    .btn_raw (btn_run),
    .press   (run_press)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_step (
    .clk_in  (clk_in),
    .reset   (reset),
    .btn_raw (btn_step),
    .press   (step_press)
  );

  // Level switches are only synchronized; the display path tolerates bounce.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      stop_sync <= '0;
      choice_s1 <= '0;
      choice    <= '0;
      raddr_s1  <= '0;
      raddr     <= '0;
    end else begin
      stop_sync <= {stop_sync[0], sw_stop};
      choice_s1 <= choice_raw;
      choice    <= choice_s1;
      raddr_s1  <= raddr_raw;
      raddr     <= raddr_s1;
    end
  end

  assign stop = stop_sync[1];

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
    end else if (!stop) begin
      div_cnt <= div_cnt + DIV_BITS'(1);
    end
  end

  assign div_tick = (&div_cnt) & ~stop;

  // Priority inside every state: stop, then run press, then step press.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state    <= START_RUN ? ST_RUN : ST_HALT;
      running  <= START_RUN;
      cpu_tick <= 1'b0;
    end else begin
      cpu_tick <= 1'b0;
      case (state)
        ST_RUN: begin
          if (stop || run_press) begin
            state   <= ST_HALT;
            running <= 1'b0;
          end else begin
            cpu_tick <= div_tick;
          end
        end
        ST_HALT: begin
          if (!stop && run_press) begin
            state   <= ST_RUN;
            running <= 1'b1;
          end else if (!stop && step_press) begin
            state <= ST_STEP;
          end
        end
        ST_STEP: begin
          if (stop || run_press) begin
            state <= ST_HALT;
          end else if (div_tick) begin
            cpu_tick <= 1'b1;
            state    <= ST_HALT;
          end
        end
        default: begin
          state   <= ST_HALT;
          running <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      tick_cnt <= '0;
    end else if (cpu_tick) begin
      tick_cnt <= tick_cnt + 16'd1;
    end
  end

endmodule
